// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: self-tracking forwarding/hazard unit; records in-flight writes per
// post-decode stage and resolves youngest-match forwarding and Tuse-based D stalls.
module fwd_scoreboard #(
   parameter int W      = 32,
   parameter int STAGES = 3,
   parameter int NREAD  = 2,
   parameter int AW     = 5,
   parameter int TW     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issue_valid,
   input  logic [AW-1:0]         issue_addr,
   input  logic [TW-1:0]         issue_tnew,
   input  logic                  flush,
   input  logic [STAGES*W-1:0]   stage_data,
   input  logic [NREAD*AW-1:0]   rd_addr,
   input  logic [NREAD*TW-1:0]   rd_tuse,
   input  logic [NREAD*W-1:0]    rd_regfile,
   output logic [NREAD*W-1:0]    fwd_data,
   output logic [NREAD-1:0]      fwd_hit,
   output logic [NREAD-1:0]      fwd_pending,
   output logic                  stall
);

   logic [STAGES-1:0] r_valid;
   logic [AW-1:0]     r_addr [STAGES];
   logic [TW-1:0]     r_tnew [STAGES];
   logic              w_m;
   logic [TW-1:0]     w_t;
   logic [W-1:0]      w_d;

   // Back end advances every clock; a stall only turns the E entry into a bubble.
   always_ff @(posedge clk) begin
      if (!reset) r_valid <= '0;
      else begin
         r_valid[0] <= issue_valid & ~stall & ~flush & (issue_addr != '0);
         for (int k = 1; k < STAGES; k++) r_valid[k] <= r_valid[k-1];
      end
      r_addr[0] <= issue_addr;
      r_tnew[0] <= issue_tnew;
      for (int k = 1; k < STAGES; k++) begin
         r_addr[k] <= r_addr[k-1];
         r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
      end
   end

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      stall       = 1'b0;
      fwd_hit     = '0;
      fwd_pending = '0;
      fwd_data    = rd_regfile;
      w_m         = 1'b0;
      w_t         = '0;
      w_d         = '0;
      for (int i = 0; i < NREAD; i++) begin
         w_m = 1'b0;
         w_t = '0;
         w_d = '0;
         for (int k = STAGES-1; k >= 0; k--)
            if (r_valid[k] && r_addr[k] == rd_addr[i*AW +: AW] && rd_addr[i*AW +: AW] != '0) begin
               w_m = 1'b1;
               w_t = r_tnew[k];
               w_d = stage_data[k*W +: W];
            end
         fwd_hit[i]     = w_m && (w_t == '0);
         fwd_pending[i] = w_m && (w_t != '0);
         if (w_m && w_t == '0) fwd_data[i*W +: W] = w_d;
         stall = stall | (w_m && (w_t > rd_tuse[i*TW +: TW]));
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed scenarios plus randomized traffic checked against an
// issue-history model where a record k stages old has tnew = max(tnew_issue - k, 0).
module tb_fwd_scoreboard;
   localparam int W = 32, STAGES = 3, NREAD = 2, AW = 5, TW = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  issue_valid;
   logic [AW-1:0]         issue_addr;
   logic [TW-1:0]         issue_tnew;
   logic                  flush;
   logic [STAGES*W-1:0]   stage_data;
   logic [NREAD*AW-1:0]   rd_addr;
   logic [NREAD*TW-1:0]   rd_tuse;
   logic [NREAD*W-1:0]    rd_regfile;
   logic [NREAD*W-1:0]    fwd_data;
   logic [NREAD-1:0]      fwd_hit;
   logic [NREAD-1:0]      fwd_pending;
   logic                  stall;

   typedef struct packed {logic v; logic [AW-1:0] a; logic [TW-1:0] t;} rec_t;
   rec_t m_hist [STAGES];
   logic [NREAD*W-1:0] e_data;
   logic [NREAD-1:0]   e_hit, e_pend;
   logic               e_stall;
   int n_checks = 0, n_errors = 0;

   fwd_scoreboard #(.W(W), .STAGES(STAGES), .NREAD(NREAD), .AW(AW), .TW(TW)) dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_addr(issue_addr),
      .issue_tnew(issue_tnew), .flush(flush), .stage_data(stage_data), .rd_addr(rd_addr),
      .rd_tuse(rd_tuse), .rd_regfile(rd_regfile), .fwd_data(fwd_data), .fwd_hit(fwd_hit),
      .fwd_pending(fwd_pending), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic model_eval();
      bit found;
      int tn;
      e_stall = 1'b0;
      for (int i = 0; i < NREAD; i++) begin
         found = 0;
         tn = 0;
         e_hit[i] = 1'b0;
         e_pend[i] = 1'b0;
         e_data[i*W +: W] = rd_regfile[i*W +: W];
         for (int k = 0; k < STAGES; k++)
            if (!found && m_hist[k].v && m_hist[k].a == rd_addr[i*AW +: AW] && rd_addr[i*AW +: AW] != 0) begin
               found = 1;
               tn = int'(m_hist[k].t) - k;
               if (tn < 0) tn = 0;
               if (tn == 0) begin
                  e_hit[i] = 1'b1;
                  e_data[i*W +: W] = stage_data[k*W +: W];
               end else e_pend[i] = 1'b1;
               if (tn > int'(rd_tuse[i*TW +: TW])) e_stall = 1'b1;
            end
      end
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk);
      if (!reset) for (int k = 0; k < STAGES; k++) m_hist[k] = '0;
      else begin
         for (int k = STAGES-1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = {issue_valid && !e_stall && !flush && issue_addr != 0, issue_addr, issue_tnew};
      end
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_addr = '0; issue_tnew = '0; flush = 1'b0;
      rd_addr = '0; rd_tuse = '0; stage_data = '0;
      rd_regfile = {32'h0000_1111, 32'h0000_2222};
   endtask

   task automatic drain();
      idle();
      repeat (STAGES) tick();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0; issue_valid = 1'b1; issue_addr = 5'd5; issue_tnew = 2'd0;
      tick(); tick();
      reset = 1'b1; issue_valid = 1'b0;
      rd_addr[0 +: AW] = 5'd5; rd_regfile[0 +: W] = 32'hCAFE_0005;
      #1;
      n_checks++; if (fwd_hit !== 2'b00) begin n_errors++; $display("FAIL reset_hit got=%b exp=00", fwd_hit); end
      n_checks++; if (fwd_pending !== 2'b00) begin n_errors++; $display("FAIL reset_pending got=%b exp=00", fwd_pending); end
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      n_checks++; if (fwd_data !== rd_regfile) begin n_errors++; $display("FAIL reset_data got=%h exp=%h", fwd_data, rd_regfile); end
   endtask

   task automatic test_alu_chain();
      drain();
      issue_valid = 1'b1; issue_addr = 5'd8; issue_tnew = 2'd1;
      tick();
      issue_addr = 5'd7; issue_tnew = 2'd0;
      rd_addr[0 +: AW] = 5'd8; rd_tuse[0 +: TW] = 2'd0;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL alu_stall got=%b exp=1", stall); end
      n_checks++; if (fwd_pending[0] !== 1'b1) begin n_errors++; $display("FAIL alu_pending got=%b exp=1", fwd_pending[0]); end
      tick();
      issue_valid = 1'b0;
      stage_data[1*W +: W] = 32'h1234;
      rd_addr[AW +: AW] = 5'd7;
      #1;
      n_checks++; if (fwd_hit !== 2'b01) begin n_errors++; $display("FAIL alu_hit got=%b exp=01", fwd_hit); end
      n_checks++; if (fwd_data[0 +: W] !== 32'h1234) begin n_errors++; $display("FAIL alu_data got=%h exp=00001234", fwd_data[0 +: W]); end
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL alu_nostall got=%b exp=0", stall); end
      n_checks++; if (fwd_data[W +: W] !== 32'h0000_1111) begin n_errors++; $display("FAIL alu_bubble got=%h exp=00001111", fwd_data[W +: W]); end
   endtask

   task automatic test_load_use();
      drain();
      issue_valid = 1'b1; issue_addr = 5'd9; issue_tnew = 2'd2;
      tick();
      issue_valid = 1'b0;
      rd_addr[0 +: AW] = 5'd9; rd_tuse[0 +: TW] = 2'd1;
      #1;
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
      tick();
      #1;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_stall_once got=%b exp=0", stall); end
      n_checks++; if (fwd_pending[0] !== 1'b1) begin n_errors++; $display("FAIL lu_pending_m got=%b exp=1", fwd_pending[0]); end
      tick();
      stage_data[2*W +: W] = 32'hBEEF;
      #1;
      n_checks++; if (fwd_pending[0] !== 1'b0 || fwd_hit[0] !== 1'b1) begin n_errors++; $display("FAIL lu_ready got=%b/%b exp=1/0", fwd_hit[0], fwd_pending[0]); end
      n_checks++; if (fwd_data[0 +: W] !== 32'hBEEF) begin n_errors++; $display("FAIL lu_data got=%h exp=0000beef", fwd_data[0 +: W]); end
   endtask

   task automatic test_youngest();
      drain();
      issue_valid = 1'b1; issue_addr = 5'd4; issue_tnew = 2'd0;
      tick(); tick();
      issue_valid = 1'b0;
      stage_data[0 +: W] = 32'hBBBB; stage_data[W +: W] = 32'hAAAA;
      rd_addr[0 +: AW] = 5'd4;
      #1;
      n_checks++; if (fwd_data[0 +: W] !== 32'hBBBB) begin n_errors++; $display("FAIL youngest_data got=%h exp=0000bbbb", fwd_data[0 +: W]); end
   endtask

   task automatic test_zero();
      drain();
      issue_valid = 1'b1; issue_addr = 5'd0; issue_tnew = 2'd3;
      tick();
      issue_valid = 1'b0;
      rd_addr[0 +: AW] = 5'd0; rd_tuse[0 +: TW] = 2'd0;
      #1;
      n_checks++; if (fwd_hit[0] !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL zero_reg got=%b/%b exp=0/0", fwd_hit[0], stall); end
      n_checks++; if (fwd_data[0 +: W] !== 32'h2222) begin n_errors++; $display("FAIL zero_data got=%h exp=00002222", fwd_data[0 +: W]); end
   endtask

   task automatic test_flush();
      drain();
      issue_valid = 1'b1; issue_addr = 5'd6; issue_tnew = 2'd0;
      tick();
      issue_valid = 1'b0;
      tick();
      issue_valid = 1'b1; issue_addr = 5'd3; flush = 1'b1;
      tick();
      issue_valid = 1'b0; flush = 1'b0;
      stage_data[2*W +: W] = 32'h6666;
      rd_addr = {5'd6, 5'd3};
      #1;
      n_checks++; if (fwd_hit !== 2'b10 || stall !== 1'b0) begin n_errors++; $display("FAIL flush_hit got=%b/%b exp=10/0", fwd_hit, stall); end
      n_checks++; if (fwd_data !== {32'h6666, 32'h2222}) begin n_errors++; $display("FAIL flush_data got=%h exp=%h", fwd_data, {32'h6666, 32'h2222}); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 29) != 0);
         issue_valid = 1'($urandom);
         issue_addr = AW'($urandom_range(0, 7));
         issue_tnew = TW'($urandom);
         flush = ($urandom_range(0, 7) == 0);
         for (int k = 0; k < STAGES; k++) stage_data[k*W +: W] = $urandom;
         for (int i = 0; i < NREAD; i++) begin
            rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            rd_tuse[i*TW +: TW] = TW'($urandom);
            rd_regfile[i*W +: W] = $urandom;
         end
         #1;
         model_eval();
         n_checks++; if (stall !== e_stall) begin n_errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, e_stall); end
         n_checks++; if (fwd_hit !== e_hit) begin n_errors++; $display("FAIL rnd_hit n=%0d got=%b exp=%b", n, fwd_hit, e_hit); end
         n_checks++; if (fwd_pending !== e_pend) begin n_errors++; $display("FAIL rnd_pending n=%0d got=%b exp=%b", n, fwd_pending, e_pend); end
         n_checks++; if (fwd_data !== e_data) begin n_errors++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, fwd_data, e_data); end
         tick();
      end
   endtask

   initial begin
      for (int k = 0; k < STAGES; k++) m_hist[k] = '0;
      reset = 1'b0;
      test_reset();
      test_alu_chain();
      test_load_use();
      test_youngest();
      test_zero();
      test_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
